// File: rtl/joypad_port.sv
// $4016 controller register and periodic NES pad poller driving a 4021-style shift chain.
// Define JOYPAD_P2_EN to add a second pad (PAD2_DATA) read through $4017.
module joypad_port #(
    parameter int POLL_DIV  = 29830,
    parameter int LATCH_CYC = 22,
    parameter int HALF_CYC  = 11
) (
    input  logic        Clk,
    input  logic        Res_n,
    input  logic [15:0] ADDR,
    input  logic        CPU_WR,
    input  logic [7:0]  CPU_DO,
    output logic [7:0]  JOY_Q,
    output logic        JOY_SEL,
    output logic        PAD_LATCH,
    output logic        PAD_CLK,
    input  logic        PAD_DATA,
`ifdef JOYPAD_P2_EN
    input  logic        PAD2_DATA,
`endif
    output logic [7:0]  BUTTONS
);
    // state    | meaning
    // IDLE     | waiting out the poll interval, pad pins idle
    // LATCH    | PAD_LATCH high, pad parallel-loads; bit 0 sampled on the last cycle
    // SHIFT_LO | PAD_CLK low half-period
    // SHIFT_HI | PAD_CLK high half-period; next bit sampled on the last cycle
    typedef enum logic [1:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI} poll_state_t;

    localparam int CNT_TOP = (POLL_DIV > LATCH_CYC)
                           ? ((POLL_DIV > HALF_CYC) ? POLL_DIV : HALF_CYC)
                           : ((LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC);
    localparam int CNT_W = $clog2(CNT_TOP);

    poll_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [2:0]       idx;
    logic [6:0]       tmp;
    logic [1:0]       pad_sync;
    logic             strobe;
    logic [7:0]       shift;
    logic             sel_p1, rd_p1, wr_p1;
    logic             unused_cpu_do;

    assign sel_p1 = (ADDR == 16'h4016);
    assign rd_p1  = sel_p1 & CPU_WR;
    assign wr_p1  = sel_p1 & ~CPU_WR;
    assign unused_cpu_do = ^CPU_DO[7:1];

`ifdef JOYPAD_P2_EN
    logic [6:0] tmp2;
    logic [1:0] pad2_sync;
    logic [7:0] buttons2;
    logic [7:0] shift2;
    logic       sel_p2, rd_p2;

    assign sel_p2 = (ADDR == 16'h4017);
    assign rd_p2  = sel_p2 & CPU_WR;
`endif

    always_ff @(posedge Clk) begin
        if (!Res_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        case (state)
            IDLE: begin
                last = (cnt == CNT_W'(POLL_DIV - 1));
                if (last) state_nxt = LATCH;
            end
            LATCH: begin
                last = (cnt == CNT_W'(LATCH_CYC - 1));
                if (last) state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                last = (cnt == CNT_W'(HALF_CYC - 1));
                if (last) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                last = (cnt == CNT_W'(HALF_CYC - 1));
                if (last) state_nxt = (idx == 3'd7) ? IDLE : SHIFT_LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bits are shifted in at the top of tmp, so bit 0 ends up in tmp[0] after seven captures.
    always_ff @(posedge Clk) begin
        if (!Res_n) begin
            cnt       <= '0;
            idx       <= 3'd0;
            tmp       <= 7'd0;
            pad_sync  <= 2'b11;
            BUTTONS   <= 8'h00;
            PAD_LATCH <= 1'b0;
            PAD_CLK   <= 1'b1;
`ifdef JOYPAD_P2_EN
            tmp2      <= 7'd0;
            pad2_sync <= 2'b11;
            buttons2  <= 8'h00;
`endif
        end else begin
            pad_sync  <= {pad_sync[0], PAD_DATA};
            cnt       <= last ? '0 : cnt + 1'b1;
            PAD_LATCH <= (state_nxt == LATCH);
            PAD_CLK   <= (state_nxt != SHIFT_LO);
`ifdef JOYPAD_P2_EN
            pad2_sync <= {pad2_sync[0], PAD2_DATA};
`endif
            if (last && state == LATCH) begin
                tmp <= {~pad_sync[1], tmp[6:1]};
                idx <= 3'd1;
`ifdef JOYPAD_P2_EN
                tmp2 <= {~pad2_sync[1], tmp2[6:1]};
`endif
            end
            if (last && state == SHIFT_HI) begin
                if (idx == 3'd7) begin
                    BUTTONS <= {~pad_sync[1], tmp};
`ifdef JOYPAD_P2_EN
                    buttons2 <= {~pad2_sync[1], tmp2};
`endif
                end else begin
                    tmp <= {~pad_sync[1], tmp[6:1]};
                    idx <= idx + 3'd1;
`ifdef JOYPAD_P2_EN
                    tmp2 <= {~pad2_sync[1], tmp2[6:1]};
`endif
                end
            end
        end
    end

    // A registered strobe of 1 keeps reloading, so the 1->0 write edge still loads.
    always_ff @(posedge Clk) begin
        if (!Res_n) begin
            strobe <= 1'b0;
            shift  <= 8'h00;
`ifdef JOYPAD_P2_EN
            shift2 <= 8'h00;
`endif
        end else begin
            if (wr_p1) strobe <= CPU_DO[0];
            if (strobe)     shift <= BUTTONS;
            else if (rd_p1) shift <= {1'b1, shift[7:1]};
`ifdef JOYPAD_P2_EN
            if (strobe)     shift2 <= buttons2;
            else if (rd_p2) shift2 <= {1'b1, shift2[7:1]};
`endif
        end
    end

    always_comb begin
        JOY_SEL = sel_p1;
        JOY_Q   = 8'h40;
        if (sel_p1) JOY_Q = {7'b0100000, shift[0]};
`ifdef JOYPAD_P2_EN
        if (sel_p2) begin
            JOY_SEL = 1'b1;
            JOY_Q   = {7'b0100000, shift2[0]};
        end
`endif
    end

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port: directed test-plan sequences plus random bus/pad traffic
// checked every cycle against a cycle-count/read-index model of the port.
module tb_joypad_port;
    localparam int PD = 60;
    localparam int LC = 6;
    localparam int HC = 4;
    localparam int P  = PD + LC + 14 * HC;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        cpu_wr = 1'b1;
    logic [7:0]  cpu_do = 8'h00;
    logic [7:0]  joy_q;
    logic        joy_sel;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad_data;
    logic [7:0]  buttons;

    logic [7:0]  pressed = 8'h00;
    logic [7:0]  pad_sr = 8'hFF;
    int          clk_falls = 0;
    int          total = 0;
    int          bad = 0;
    logic        chk_en = 1'b0;
    logic        rand_pad = 1'b0;

    // reference model state
    int          cyc = 0;
    logic [7:0]  m_buttons = 8'h00;
    logic [7:0]  m_latched = 8'h00;
    logic [7:0]  m_val = 8'h00;
    int          m_k = 0;
    logic        m_strobe = 1'b0;

`ifdef JOYPAD_P2_EN
    logic        pad2_data;
    logic [7:0]  pressed2 = 8'h80;
    logic [7:0]  pad2_sr = 8'hFF;
    logic [7:0]  m_buttons2 = 8'h00;
    logic [7:0]  m_latched2 = 8'h00;
    logic [7:0]  m_val2 = 8'h00;
    int          m_k2 = 0;
    localparam bit P2 = 1'b1;
`else
    localparam bit P2 = 1'b0;
`endif

    joypad_port #(.POLL_DIV(PD), .LATCH_CYC(LC), .HALF_CYC(HC)) dut (
        .Clk       (clk),
        .Res_n     (res_n),
        .ADDR      (addr),
        .CPU_WR    (cpu_wr),
        .CPU_DO    (cpu_do),
        .JOY_Q     (joy_q),
        .JOY_SEL   (joy_sel),
        .PAD_LATCH (pad_latch),
        .PAD_CLK   (pad_clk),
        .PAD_DATA  (pad_data),
`ifdef JOYPAD_P2_EN
        .PAD2_DATA (pad2_data),
`endif
        .BUTTONS   (buttons)
    );

    always #5 clk = ~clk;

    // 4021-style pad: parallel load while latched, shift on clock rise, active-low data
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_sr <= ~pressed;
        else           pad_sr <= {1'b1, pad_sr[7:1]};
    end
    assign pad_data = pad_sr[0];

`ifdef JOYPAD_P2_EN
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad2_sr <= ~pressed2;
        else           pad2_sr <= {1'b1, pad2_sr[7:1]};
    end
    assign pad2_data = pad2_sr[0];
`endif

    always @(negedge pad_clk) clk_falls <= clk_falls + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_latch();
        int t;
        t = cyc % P;
        return (t >= PD) && (t < PD + LC);
    endfunction

    function automatic logic exp_pclk();
        int u;
        u = (cyc % P) - PD - LC;
        if (u >= 0 && u < 14 * HC && (u % (2 * HC)) < HC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic rd_bit(input logic [7:0] v, input int k);
        if (k >= 8) return 1'b1;
        return v[k[2:0]];
    endfunction

    function automatic logic exp_sel();
        if (addr == 16'h4016) return 1'b1;
        if (P2 && addr == 16'h4017) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_q();
        if (addr == 16'h4016) return {7'b0100000, rd_bit(m_val, m_k)};
`ifdef JOYPAD_P2_EN
        if (addr == 16'h4017) return {7'b0100000, rd_bit(m_val2, m_k2)};
`endif
        return 8'h40;
    endfunction

    // advance the model across one rising edge, using the inputs present at that edge
    task automatic model_edge();
        int t;
        if (!res_n) begin
            cyc = 0; m_buttons = 8'h00; m_strobe = 1'b0; m_val = 8'h00; m_k = 0;
`ifdef JOYPAD_P2_EN
            m_buttons2 = 8'h00; m_val2 = 8'h00; m_k2 = 0;
`endif
            return;
        end
        t = cyc % P;
        if (t == PD - 1) begin
            m_latched = pressed;
`ifdef JOYPAD_P2_EN
            m_latched2 = pressed2;
`endif
        end
        if (m_strobe) begin
            m_val = m_buttons; m_k = 0;
`ifdef JOYPAD_P2_EN
            m_val2 = m_buttons2; m_k2 = 0;
`endif
        end else begin
            if (cpu_wr && addr == 16'h4016 && m_k < 8) m_k++;
`ifdef JOYPAD_P2_EN
            if (cpu_wr && addr == 16'h4017 && m_k2 < 8) m_k2++;
`endif
        end
        if (!cpu_wr && addr == 16'h4016) m_strobe = cpu_do[0];
        if (t == P - 1) begin
            m_buttons = m_latched;
`ifdef JOYPAD_P2_EN
            m_buttons2 = m_latched2;
`endif
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic wr, input logic [7:0] d);
        addr = a; cpu_wr = wr; cpu_do = d;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b0, d);
        tick();
        bus(16'h0000, 1'b1, 8'h00);
    endtask

    task automatic cpu_read_chk(input logic [15:0] a, input logic [7:0] exp, input string name);
        bus(a, 1'b1, 8'h00);
        #1;
        chk(name, {24'h0, joy_q}, {24'h0, exp});
        tick();
        bus(16'h0000, 1'b1, 8'h00);
    endtask

    task automatic wait_t(input int target);
        for (int i = 0; i < P + 1; i++) begin
            if (cyc % P == target) break;
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("PAD_LATCH", {31'h0, pad_latch}, {31'h0, exp_latch()});
            chk("PAD_CLK",   {31'h0, pad_clk},   {31'h0, exp_pclk()});
            chk("BUTTONS",   {24'h0, buttons},   {24'h0, m_buttons});
            chk("JOY_SEL",   {31'h0, joy_sel},   {31'h0, exp_sel()});
            chk("JOY_Q",     {24'h0, joy_q},     {24'h0, exp_q()});
        end
    end

    initial begin
        logic [7:0] exp09 [10];
        logic [7:0] exp82 [8];
        int f0;
        int n;
        int r;
        exp09 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
        exp82 = '{8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};

        // reset
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst PAD_CLK",   {31'h0, pad_clk},   32'h1);
        chk("rst PAD_LATCH", {31'h0, pad_latch}, 32'h0);
        chk("rst BUTTONS",   {24'h0, buttons},   32'h0);
        res_n = 1'b1;

        // one poll with A and Start held
        pressed = 8'h09;
        f0 = clk_falls;
        repeat (P) tick();
        chk("poll clk pulses", clk_falls - f0, 7);
        chk("poll BUTTONS", {24'h0, buttons}, 32'h09);

        // strobe 1->0 then ten reads
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 10; i++) cpu_read_chk(16'h4016, exp09[i], "serial read");

        // strobe held high: reads return A and do not shift
        cpu_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) cpu_read_chk(16'h4016, 8'h41, "strobe-high read");
        cpu_write(16'h4016, 8'h00);
        cpu_read_chk(16'h4016, 8'h41, "post-strobe read0");
        cpu_read_chk(16'h4016, 8'h40, "post-strobe read1");

        // strobe release on the same edge as a 09->82 commit
        wait_t(2);
        pressed = 8'h82;
        cpu_write(16'h4016, 8'h01);
        wait_t(P - 1);
        chk("pre-commit BUTTONS", {24'h0, buttons}, 32'h09);
        bus(16'h4016, 1'b0, 8'h00);
        tick();
        bus(16'h0000, 1'b1, 8'h00);
        chk("commit BUTTONS", {24'h0, buttons}, 32'h82);
        cpu_read_chk(16'h4016, 8'h41, "old A after commit");
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) cpu_read_chk(16'h4016, exp82[i], "read 82");

        // reset during SHIFT_LO
        wait_t(PD + LC + 1);
        chk("in SHIFT_LO", {31'h0, pad_clk}, 32'h0);
        res_n = 1'b0;
        tick();
        chk("midpoll rst PAD_CLK",   {31'h0, pad_clk},   32'h1);
        chk("midpoll rst PAD_LATCH", {31'h0, pad_latch}, 32'h0);
        chk("midpoll rst BUTTONS",   {24'h0, buttons},   32'h0);
        res_n = 1'b1;
        n = 0;
        while (n < PD + 8 && !pad_latch) begin
            tick();
            n++;
        end
        chk("poll restart delay", n, PD);

        // second port: pad2 holds Right only
        wait_t(1);
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++)
            cpu_read_chk(16'h4017, (P2 && i == 7) ? 8'h41 : 8'h40, "read 4017");
        cpu_read_chk(16'h4016, 8'h40, "4016 after 4017 reads0");
        cpu_read_chk(16'h4016, 8'h41, "4016 after 4017 reads1");

        // random traffic, random pad contents, occasional reset
        rand_pad = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      addr = 16'h4016;
            else if (r < 7) addr = 16'h4017;
            else            addr = 16'($urandom);
            cpu_wr = ($urandom_range(0, 7) != 0);
            cpu_do = 8'($urandom);
            res_n  = ($urandom_range(0, 799) != 0);
            if (rand_pad && (cyc % P) < PD - 4 && $urandom_range(0, 19) == 0) begin
                pressed = 8'($urandom);
`ifdef JOYPAD_P2_EN
                pressed2 = 8'($urandom);
`endif
            end
            tick();
        end
        res_n = 1'b1;
        bus(16'h0000, 1'b1, 8'h00);
        repeat (5) tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/joypad_port.md
Name: joypad_port

Overview:
- CPU-bus responder for the standard controller register at $4016, answering the T65 bus master through the databus mux.
- Also the master of the physical NES pad: a 4021-style shift chain on Arduino pins, driven through latch, clock and data lines.
- Polls the pad periodically into a button register.
- Provides the CPU the strobe/serial-read semantics.

Parameters:
- POLL_DIV, 29830, Clk cycles between pad poll starts (~60 Hz at CLK_NES ≈1.79 MHz)
- LATCH_CYC, 22, Clk cycles PAD_LATCH held high (~12 us)
- HALF_CYC, 11, Clk cycles per PAD_CLK phase; minimum 4

Ports:
- Clk  in  1  CPU bus clock (CLK_NES)
- Res_n  in  1  synchronous active-low reset
- ADDR  in  16  CPU address (bus_addr[15:0])
- CPU_WR  in  1  T65 R_W_n: 1 = read, 0 = write
- CPU_DO  in  8  CPU write data
- JOY_Q  out  8  read data to databus mux
- JOY_SEL  out  1  combinational: ADDR is a decoded joypad address
- PAD_LATCH  out  1  pad parallel-load strobe, active high
- PAD_CLK  out  1  pad shift clock, idles high
- PAD_DATA  in  1  pad serial data, active low (asynchronous)
- BUTTONS  out  8  last completed poll, active high, for LEDR debug

Behaviour:
- Reset (Res_n=0 at a Clk edge) sets:
  - poll FSM=IDLE, poll counter=0
  - PAD_LATCH=0, PAD_CLK=1, BUTTONS=8'h00
  - strobe=0, shift=8'h00, sync flops=1
- Reset mid-poll discards partial data and returns the pins to idle on the same edge.
- Bit order (BUTTONS and shift): [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- PAD_DATA passes through a 2-flop synchronizer. All sampling uses the synced value.
- Poll FSM:
  - IDLE: count to POLL_DIV-1, then go to LATCH. Counter clears on each state change.
  - LATCH: PAD_LATCH=1 for LATCH_CYC cycles. On the last cycle, capture ~sync into tmp[0], then go to SHIFT_LO with bit index=1.
  - SHIFT_LO: PAD_CLK=0 for HALF_CYC cycles, then go to SHIFT_HI.
  - SHIFT_HI: PAD_CLK=1 for HALF_CYC cycles. On the last cycle, capture ~sync into tmp[index].
    - index<7: index++, go to SHIFT_LO.
    - index=7: BUTTONS<=tmp with the captured bit merged in, go to IDLE.
  - Seven clock pulses per poll; one full poll completes every POLL_DIV + LATCH_CYC + 14*HALF_CYC cycles.
- Decode: JOY_SEL=1 iff ADDR==16'h4016 (plus $4017 under the optional feature).
- JOY_Q:
  - Combinational: {7'b0100000, shift[0]} when selecting $4016.
  - 8'h40 otherwise.
  - Open-bus bit 6 is high.
- Write: CPU_WR=0 and ADDR==$4016 → strobe<=CPU_DO[0] at the edge. CPU_DO[7:1] is ignored.
- Shift register update, one cycle per T65 bus access:
  - Load: any cycle with registered strobe=1 → shift<=BUTTONS at the edge. Reads during this state return current A and do not shift. The cycle that writes strobe 1→0 still loads, which freezes the state.
  - Read: strobe=0, CPU_WR=1, ADDR==$4016 → shift<={1'b1, shift[7:1]} at the edge. JOY_Q shows the pre-shift shift[0] during the cycle.
  - Back-to-back read cycles each shift. After 8 reads, all reads return 1.
- Simultaneous BUTTONS commit and strobe load: the load takes the pre-commit BUTTONS value; the new value is seen on the next cycle.
- The poll FSM runs independently of CPU accesses.
- Writes to other addresses and reads with JOY_SEL=0 have no side effects.

Optional Feature:
- Macro: JOYPAD_P2_EN.
- Defined:
  - Adds input PAD2_DATA (1 bit, active low) with its own synchronizer, shared PAD_LATCH/PAD_CLK, BUTTONS2 capture and a second shift register.
  - $4017 is decoded: JOY_SEL=1 and JOY_Q={7'b0100000, shift2[0]}.
  - Reads of $4017 shift shift2 under the same rules as $4016.
  - The $4016 strobe write loads both shift registers. Writes to $4017 are ignored (JOY_SEL=1).
  - BUTTONS output is unchanged (player 1 only).
- Undefined: no PAD2_DATA port; $4017 is not decoded (JOY_SEL=0, no side effects).

Test Plan:
- Reset then run one poll with a pad model holding A and Start (PAD_DATA=0 on bits 0,3) → PAD_CLK shows 7 low pulses, BUTTONS=8'h09 after the poll.
- BUTTONS=8'h09; write $01 then $00 to $4016; 10 consecutive reads of $4016 → JOY_Q = 41,40,40,41,40,40,40,40,41,41.
- Strobe held 1 (write $01); 3 reads of $4016 → each returns 8'h41; shift is unchanged.
- Strobe write 1→0 on the same edge as a BUTTONS commit 09→82 → first read returns the old A (41); re-strobe, then reads yield 8'h82's bits.
- Assert Res_n=0 during SHIFT_LO → next edge PAD_CLK=1, PAD_LATCH=0, BUTTONS=0; the next poll starts POLL_DIV cycles after release.
- With JOYPAD_P2_EN, pad2 pressing Right (bit 7) → 8th read of $4017 returns 8'h41, all earlier reads 8'h40; $4016 reads are unaffected.
